// File: rtl/serial_pair_serializer_if.sv
// Word-pair handshake and serial bit bus of serial_pair_serializer.
// master = serializer side, slave = upstream source / downstream comparator side.
interface serial_pair_serializer_if #(
  parameter int WIDTH = 8
);
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_a;
  logic [WIDTH-1:0] up_b;
  logic             cmp_rst;
  logic             bit_valid;
  logic             down_ready;
  logic             a;
  logic             b;
  logic             last;

  modport master (
    input  up_valid, up_a, up_b, down_ready,
    output up_ready, cmp_rst, bit_valid, a, b, last
  );

  modport slave (
    output up_valid, up_a, up_b, down_ready,
    input  up_ready, cmp_rst, bit_valid, a, b, last
  );
endinterface

// File: rtl/serial_pair_serializer.sv
// Serializes (a, b) word pairs into aligned bit streams, preceded by a one-cycle comparator clear.
// Define SERIALIZER_LSB_FIRST_EN to shift LSB first instead of the default MSB first.
module serial_pair_serializer #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_pair_serializer_if.master  bus
);
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  logic             head_a, head_b;
  logic             at_last, xfer, load;

`ifdef SERIALIZER_LSB_FIRST_EN
  assign head_a = sh_a[0];
  assign head_b = sh_b[0];
`else
  assign head_a = sh_a[WIDTH-1];
  assign head_b = sh_b[WIDTH-1];
`endif

  assign at_last = (state == SHIFT) && (cnt == CNT_LAST);
  assign xfer    = (state == SHIFT) && bus.down_ready;
  assign load    = bus.up_ready && bus.up_valid;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.up_valid) state_nxt = CLEAR;
      CLEAR:   state_nxt = SHIFT;
      SHIFT:   if (xfer && at_last) state_nxt = bus.up_valid ? CLEAR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A load on the last-bit transfer wins over the shift; the new word restarts the counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_a <= '0;
      sh_b <= '0;
      cnt  <= '0;
    end else if (load) begin
      sh_a <= bus.up_a;
      sh_b <= bus.up_b;
      cnt  <= '0;
    end else if (xfer) begin
`ifdef SERIALIZER_LSB_FIRST_EN
      sh_a <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b <= {1'b0, sh_b[WIDTH-1:1]};
`else
      sh_a <= {sh_a[WIDTH-2:0], 1'b0};
      sh_b <= {sh_b[WIDTH-2:0], 1'b0};
`endif
      cnt  <= at_last ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    bus.up_ready  = 1'b0;
    bus.cmp_rst   = 1'b0;
    bus.bit_valid = 1'b0;
    bus.a         = 1'b0;
    bus.b         = 1'b0;
    bus.last      = 1'b0;
    case (state)
      IDLE:  bus.up_ready = 1'b1;
      CLEAR: bus.cmp_rst  = 1'b1;
      SHIFT: begin
        bus.bit_valid = 1'b1;
        bus.a         = head_a;
        bus.b         = head_b;
        bus.last      = at_last;
        bus.up_ready  = bus.down_ready & at_last;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_serial_pair_serializer.sv
// Cycle bench for serial_pair_serializer: directed plan scenarios then random traffic,
// checked against a word/bit-index reference model and an attached serial comparator.
module tb_serial_pair_serializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_pair_serializer_if #(.WIDTH(W)) bus ();
  serial_pair_serializer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: phase 0 idle, 1 clear, 2 sending bit number idx of the held word pair.
  int             ph   = 0;
  int             idx  = 0;
  int             nacc = 0;
  logic [W-1:0]   wa   = '0;
  logic [W-1:0]   wb   = '0;
  int             cmp  = 0;  // attached comparator: 0 eq, 1 a<b, 2 a>b

  function automatic int bpos(input int i);
`ifdef SERIALIZER_LSB_FIRST_EN
    return i;
`else
    return W - 1 - i;
`endif
  endfunction

  function automatic int rel(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x > y) ? 2 : ((x < y) ? 1 : 0);
  endfunction

  task automatic cyc(input logic r, input logic uv, input logic [W-1:0] ua,
                     input logic [W-1:0] ub, input logic dr, input string tag);
    logic ev, ea, eb, el, ec, eu;
    int   ncmp;
    @(negedge clk);
    rst            = r;
    bus.up_valid   = uv;
    bus.up_a       = ua;
    bus.up_b       = ub;
    bus.down_ready = dr;
    #1;
    ev = (ph == 2);
    ea = ev && wa[bpos(idx)];
    eb = ev && wb[bpos(idx)];
    el = ev && (idx == W - 1);
    ec = (ph == 1);
    eu = (ph == 0) || (el && dr);
    chk({tag, ".outs"},
        {26'd0, bus.up_ready, bus.cmp_rst, bus.bit_valid, bus.a, bus.b, bus.last},
        {26'd0, eu, ec, ev, ea, eb, el});

    ncmp = cmp;
    if (bus.bit_valid && dr && (bus.a != bus.b)) begin
`ifdef SERIALIZER_LSB_FIRST_EN
      ncmp = bus.a ? 2 : 1;
`else
      if (cmp == 0) ncmp = bus.a ? 2 : 1;
`endif
    end
    if (el && dr) chk({tag, ".cmp"}, ncmp, rel(wa, wb));
    cmp = bus.cmp_rst ? 0 : ncmp;

    if (!r) begin
      ph = 0; idx = 0;
    end else if (eu && uv) begin
      ph = 1; wa = ua; wb = ub; nacc++;
    end else if (ph == 1) begin
      ph = 2; idx = 0;
    end else if (ph == 2 && dr) begin
      if (el) ph = 0;
      else    idx++;
    end
  endtask

  initial begin
    int base, k;
    bus.up_valid   = 1'b0;
    bus.up_a       = '0;
    bus.up_b       = '0;
    bus.down_ready = 1'b0;

    repeat (2) cyc(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, "reset");
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, "post_reset");

    // basic word
    cyc(1'b1, 1'b1, 8'hA5, 8'hA4, 1'b1, "basic");
    repeat (10) cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, "basic");

    // back-to-back with up_valid held
    base = nacc;
    for (int i = 0; i < 22; i++) begin
      k = nacc - base;
      cyc(1'b1, k < 2, (k == 0) ? 8'h3C : 8'h01, (k == 0) ? 8'h3C : 8'h02, 1'b1, "b2b");
    end

    // stall three cycles on the third bit
    cyc(1'b1, 1'b1, 8'h5A, 8'hC3, 1'b1, "stall");
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "stall");
    repeat (2) cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, "stall");
    repeat (3) cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "stall");
    repeat (8) cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, "stall");

    // busy hold-off: next pair offered during the whole word
    cyc(1'b1, 1'b1, 8'h96, 8'h69, 1'b1, "hold");
    base = nacc;
    for (int i = 0; i < 20 && nacc == base; i++)
      cyc(1'b1, 1'b1, 8'h11, 8'h22, 1'b1, "hold");
    repeat (10) cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, "hold");

    // reset at bit 4, then a fresh word
    cyc(1'b1, 1'b1, 8'hE7, 8'h18, 1'b1, "midrst");
    repeat (5) cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, "midrst");
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "midrst");
    cyc(1'b1, 1'b1, 8'hF0, 8'h0F, 1'b1, "midrst");
    repeat (10) cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, "midrst");

    // bit-order probe
    cyc(1'b1, 1'b1, 8'h01, 8'h80, 1'b1, "order");
    repeat (10) cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, "order");

    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 1) == 1),
          W'($urandom), W'($urandom), ($urandom_range(0, 3) != 0), "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_pair_serializer.md
# serial_pair_serializer

Parallel-to-serial transmitter feeding the serial comparators. Accepts a pair of WIDTH-bit words (a, b) over a valid/ready handshake and shifts them out one bit per transfer, both streams aligned, most significant bit first. Drives a one-cycle clear pulse to the downstream comparator before each word and flags the last bit, so the comparator's output on the last-bit cycle is the full-word result.

## Interface

- WIDTH, default 8, bits per word; legal range WIDTH >= 2.

- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- up_valid  input  1  upstream word pair present.
- up_ready  output  1  serializer accepts a word pair this cycle.
- up_a  input  WIDTH  word a.
- up_b  input  WIDTH  word b.
- cmp_rst  output  1  one-cycle clear pulse to the downstream comparator, active-high.
- bit_valid  output  1  a/b carry a valid bit.
- down_ready  input  1  downstream consumes the bit this cycle.
- a  output  1  serial bit of word a.
- b  output  1  serial bit of word b.
- last  output  1  current bit is the final bit of the word (LSB in default build).

## Operation

- FSM states: IDLE, CLEAR, SHIFT.
- IDLE: up_ready=1, bit_valid=0. On up_valid: load up_a/up_b into shift registers, go to CLEAR.
- CLEAR: lasts exactly one cycle. cmp_rst=1, bit_valid=0, up_ready=0. down_ready ignored. Next state SHIFT, bit counter=0.
- SHIFT: bit_valid=1. a/b = current head bit of each shift register. A transfer is bit_valid & down_ready. On transfer, shift both registers by one and increment the counter. last=1 when counter == WIDTH-1.
- Stall: down_ready=0 in SHIFT holds a, b, last, and the counter unchanged.
- End of word: transfer with last=1. up_ready=1 in that same cycle (combinational: down_ready & last). If up_valid=1, load the new pair and go to CLEAR; otherwise go to IDLE.
- up_ready=0 in SHIFT except on the last-bit transfer. A pending up_valid is held off, not dropped.
- a, b, and last are 0 whenever bit_valid=0.
- Counter width is $clog2(WIDTH). It never exceeds WIDTH-1.

## Timing

- Reset (rst=0 at a clock edge): state IDLE, bit_valid=0, a=0, b=0, last=0, cmp_rst=0. up_ready=1 from the first cycle after release.
- Reset mid-word: the word is discarded with no further bits and no cmp_rst. The block is in IDLE in the cycle after the reset edge.
- Latency without stalls, word accepted at cycle T:
  - cmp_rst at T+1.
  - First bit at T+2.
  - Last bit at T+1+WIDTH.
- Throughput: one word per WIDTH+1 cycles with up_valid held. The only gap between words is the CLEAR cycle.
- Each down_ready=0 cycle in SHIFT adds one cycle of latency.
- up_valid and up_a/up_b are sampled only when up_ready=1.

## Configuration

- SERIALIZER_LSB_FIRST_EN undefined (default): bits are shifted out MSB first. The first bit is up_a[WIDTH-1]/up_b[WIDTH-1]; last marks bit 0.
- SERIALIZER_LSB_FIRST_EN defined: bits are shifted out LSB first. The first bit is up_a[0]/up_b[0]; last marks bit WIDTH-1. Use this build to feed the least-significant-first comparator.
- Handshake, CLEAR cycle, and timing are identical in both builds.

## Test plan

- Basic word, WIDTH=8, a=0xA5, b=0xA4, down_ready=1, accepted at T:
  - cmp_rst=1 at T+1.
  - a bits 1,0,1,0,0,1,0,1 and b bits 1,0,1,0,0,1,0,0 at T+2..T+9.
  - last=1 only at T+9.
  - Attached MSB-first comparator shows a_greater_b=1 at T+9.
- Back-to-back pairs, up_valid held, pairs (0x3C,0x3C) then (0x01,0x02):
  - Second pair accepted on the first pair's last-bit cycle.
  - Single cmp_rst cycle between words.
  - Comparator shows a_eq_b=1 at the end of word 1 and a_less_b=1 at the end of word 2.
- Stall: down_ready=0 for 3 cycles while the third bit is presented.
  - a, b, and last hold for those cycles.
  - Total word duration extends by 3; bit sequence unchanged.
- Busy hold-off: up_valid=1 with a new pair during bits 0..WIDTH-2.
  - up_ready=0 throughout.
  - Pair accepted only on the last-bit transfer; its values unchanged.
- Reset mid-word: rst=0 for one cycle at bit 4.
  - Next cycle: bit_valid=0, up_ready=1, cmp_rst=0, last=0.
  - A new word afterwards serializes correctly.
- SERIALIZER_LSB_FIRST_EN build, a=0x01, b=0x80:
  - First bit a=1, b=0.
  - Final bit (last=1) a=0, b=1.
